// File: rtl/regfile_wb_sequencer.sv
// Write-back scheduler for a single-write-port Y86-64 register file.
// Splits dual-destination transactions into an E write followed by an M write.
module regfile_wb_sequencer #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        dstE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [14:0]       pend_mask,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic {
    S_IDLE,
    S_ISSUE_M
  } state_t;

  state_t state, state_nxt;

  logic              accept;
  logic              e_valid;
  logic              m_valid;
  logic              split;

  logic              wr_en_nxt;
  logic [3:0]        wr_addr_nxt;
  logic [DATA_W-1:0] wr_data_nxt;

  logic              m_load;
  logic [3:0]        m_addr;
  logic [DATA_W-1:0] m_data;

  // Ready is gated by reset directly so it drops without waiting for an edge.
  assign wb_ready = (state == S_IDLE) && !reset;
  assign accept   = wb_valid && wb_ready;
  assign e_valid  = (dstE != REG_NONE);
  assign m_valid  = (dstM != REG_NONE);
  assign split    = e_valid && m_valid && (dstE != dstM);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept && split) state_nxt = S_ISSUE_M;
      S_ISSUE_M: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = REG_NONE;
    wr_data_nxt = wr_data;
    m_load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          // Same-register E/M collapses to a single write of valM (popq %rsp).
          if (m_valid && !split) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = dstM;
            wr_data_nxt = valM;
          end else if (e_valid) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = dstE;
            wr_data_nxt = valE;
            m_load      = split;
          end
        end
      end
      S_ISSUE_M: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = m_addr;
        wr_data_nxt = m_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= REG_NONE;
      wr_data <= '0;
    end else begin
      wr_en   <= wr_en_nxt;
      wr_addr <= wr_addr_nxt;
      wr_data <= wr_data_nxt;
    end
  end

  // NOTE: the M buffer is a single register, not a memory array, so it is
  // cleared on reset; a reset in ISSUE_M must leave nothing to replay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_addr <= REG_NONE;
      m_data <= '0;
    end else if (m_load) begin
      m_addr <= dstM;
      m_data <= valM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt <= '0;
    end else if (accept) begin
      retire_cnt <= retire_cnt + 1'b1;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int r = 0; r < 15; r++) begin
      pend_mask[r] = (wr_en && (wr_addr == 4'(r))) ||
                     ((state == S_ISSUE_M) && (m_addr == 4'(r)));
    end
  end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Directed self-checking bench for regfile_wb_sequencer.
`timescale 1ns/1ps
module tb_regfile_wb_sequencer;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_valid;
  logic              wb_ready;
  logic [3:0]        dstE;
  logic [3:0]        dstM;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valM;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [14:0]       pend_mask;
  logic [CNT_W-1:0]  retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .dstE       (dstE),
    .dstM       (dstM),
    .valE       (valE),
    .valM       (valM),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pend_mask  (pend_mask),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge; inputs change and outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] de, input logic [DATA_W-1:0] ve,
                       input logic [3:0] dm, input logic [DATA_W-1:0] vm);
    wb_valid = v;
    dstE     = de;
    valE     = ve;
    dstM     = dm;
    valM     = vm;
  endtask

  task automatic chk_write(input string name, input logic en, input logic [3:0] addr,
                           input logic [DATA_W-1:0] data, input logic [14:0] mask,
                           input logic rdy, input logic [CNT_W-1:0] cnt);
    n_checks++;
    if (wr_en !== en) begin
      n_fail++; $display("FAIL %s wr_en: got %0b expected %0b", name, wr_en, en);
    end
    n_checks++;
    if (wr_addr !== addr) begin
      n_fail++; $display("FAIL %s wr_addr: got %h expected %h", name, wr_addr, addr);
    end
    n_checks++;
    if (wr_data !== data) begin
      n_fail++; $display("FAIL %s wr_data: got %h expected %h", name, wr_data, data);
    end
    n_checks++;
    if (pend_mask !== mask) begin
      n_fail++; $display("FAIL %s pend_mask: got %h expected %h", name, pend_mask, mask);
    end
    n_checks++;
    if (wb_ready !== rdy) begin
      n_fail++; $display("FAIL %s wb_ready: got %0b expected %0b", name, wb_ready, rdy);
    end
    n_checks++;
    if (retire_cnt !== cnt) begin
      n_fail++; $display("FAIL %s retire_cnt: got %0d expected %0d", name, retire_cnt, cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    #12;
    chk_write("reset_held", 1'b0, 4'hF, 64'h0, 15'h0, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    chk_write("reset_release", 1'b0, 4'hF, 64'h0, 15'h0, 1'b1, 16'd0);
  endtask

  task automatic test_single_e();
    drive(1'b1, 4'd3, 64'h11, 4'hF, 64'h0);
    step();
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    chk_write("single_e", 1'b1, 4'd3, 64'h11, 15'h0008, 1'b1, 16'd1);
    step();
    chk_write("idle_hold", 1'b0, 4'hF, 64'h11, 15'h0000, 1'b1, 16'd1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i), 64'h100 + 64'(i), 4'hF, 64'h0);
      step();
      chk_write($sformatf("b2b_%0d", i), 1'b1, 4'(i), 64'h100 + 64'(i),
                15'(1 << i), 1'b1, 16'(2 + i));
    end
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    step();
  endtask

  task automatic test_popq();
    drive(1'b1, 4'd4, 64'h108, 4'd0, 64'hAB);
    step();
    // Held inputs during ISSUE_M must be ignored and not counted.
    drive(1'b1, 4'd7, 64'hDEAD, 4'd8, 64'hBEEF);
    chk_write("popq_e", 1'b1, 4'd4, 64'h108, 15'h0011, 1'b0, 16'd5);
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    step();
    chk_write("popq_m", 1'b1, 4'd0, 64'hAB, 15'h0001, 1'b1, 16'd5);
    step();
    chk_write("popq_done", 1'b0, 4'hF, 64'hAB, 15'h0000, 1'b1, 16'd5);
  endtask

  task automatic test_same_dst();
    drive(1'b1, 4'd4, 64'h108, 4'd4, 64'h55);
    step();
    chk_write("same_dst", 1'b1, 4'd4, 64'h55, 15'h0010, 1'b1, 16'd6);
    drive(1'b1, 4'hF, 64'h77, 4'd9, 64'h99);
    step();
    chk_write("only_m", 1'b1, 4'd9, 64'h99, 15'h0200, 1'b1, 16'd7);
    drive(1'b1, 4'hF, 64'h1, 4'hF, 64'h2);
    step();
    chk_write("nop_txn", 1'b0, 4'hF, 64'h99, 15'h0000, 1'b1, 16'd8);
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    step();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'd4, 64'h108, 4'd2, 64'h22);
    step();
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    chk_write("mid_e", 1'b1, 4'd4, 64'h108, 15'h0014, 1'b0, 16'd9);
    #1;
    reset = 1'b1;
    #1;
    chk_write("mid_async", 1'b0, 4'hF, 64'h0, 15'h0000, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_write($sformatf("mid_no_m_%0d", i), 1'b0, 4'hF, 64'h0, 15'h0000, 1'b1, 16'd0);
    end
  endtask

  task automatic test_wrap();
    int wr_seen;
    wr_seen = 0;
    drive(1'b1, 4'hF, 64'h5, 4'hF, 64'h6);
    for (int i = 0; i < 65535; i++) begin
      step();
      if (wr_en !== 1'b0) wr_seen++;
    end
    n_checks++;
    if (retire_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_max retire_cnt: got %h expected ffff", retire_cnt);
    end
    step();
    if (wr_en !== 1'b0) wr_seen++;
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    n_checks++;
    if (retire_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_zero retire_cnt: got %h expected 0000", retire_cnt);
    end
    n_checks++;
    if (wr_seen != 0) begin
      n_fail++; $display("FAIL wrap_no_write wr_en cycles: got %0d expected 0", wr_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_e();
    test_back_to_back();
    test_popq();
    test_same_dst();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
